// File: rtl/lcm_eg9013f_nz_pkg.sv
// Shared encodings and panel defaults for the EG9013F-NZ frame-scan sequencer.
package lcm_eg9013f_nz_pkg;

  localparam logic [1:0] ST_IDLE_ENC  = 2'd0;
  localparam logic [1:0] ST_FETCH_ENC = 2'd1;
  localparam logic [1:0] ST_SHIFT_ENC = 2'd2;
  localparam logic [1:0] ST_LATCH_ENC = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = ST_IDLE_ENC,
    ST_FETCH = ST_FETCH_ENC,
    ST_SHIFT = ST_SHIFT_ENC,
    ST_LATCH = ST_LATCH_ENC
  } state_t;

  localparam int LCM_H_BYTES = 40;
  localparam int LCM_V_LINES = 240;

endpackage

// File: rtl/lcm_eg9013f_nz_scan_ctrl_phase_gen.sv
// Phase counter for one byte/latch period (2*XSCL_DIV cycles) and look-ahead XSCL decode.
module lcm_xscl_phase_gen #(
  parameter int XSCL_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic tc,
  output logic nxt_xscl,
  output logic nxt_prefetch,
  output logic nxt_last
);

  localparam int PH_W = $clog2(2 * XSCL_DIV);
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(2 * XSCL_DIV - 1);
  localparam logic [PH_W-1:0] PH_PRE  = PH_W'(2 * XSCL_DIV - 2);
  localparam logic [PH_W-1:0] PH_HI   = PH_W'(XSCL_DIV);

  logic [PH_W-1:0] phase;
  logic [PH_W-1:0] phase_nxt;

  assign tc = (phase == PH_LAST);

  always_comb begin
    phase_nxt = '0;
    if (!restart && !tc) phase_nxt = phase + PH_W'(1);
  end

  // Decodes of the upcoming phase so the top can register outputs aligned to it
  assign nxt_xscl     = (phase_nxt < PH_HI);
  assign nxt_prefetch = (phase_nxt == PH_PRE);
  assign nxt_last     = (phase_nxt == PH_LAST);

  always_ff @(posedge clk) begin
    if (rst) phase <= '0;
    else     phase <= phase_nxt;
  end

endmodule

// File: rtl/lcm_eg9013f_nz_scan_ctrl.sv
// Frame-scan sequencer: walks the frame buffer and drives LCM data, XSCL, LP and FLM pins.
module lcm_eg9013f_nz_scan_ctrl
  import lcm_eg9013f_nz_pkg::*;
#(
  parameter int BYTE_WIDTH = 8,
  parameter int H_BYTES    = LCM_H_BYTES,
  parameter int V_LINES    = LCM_V_LINES,
  parameter int XSCL_DIV   = 4,
  parameter int ADDR_WIDTH = 14
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [BYTE_WIDTH-1:0] rd_data,
  output logic [BYTE_WIDTH-1:0] lcm_data,
  output logic                  lcm_xscl,
  output logic                  lcm_lp,
  output logic                  lcm_din,
  output logic                  busy,
  output logic                  frame_done
);

  localparam int LW = $clog2(V_LINES + 1);
  localparam int BW = $clog2(H_BYTES + 1);
  localparam logic [LW-1:0] LINE_LAST = LW'(V_LINES - 1);
  localparam logic [BW-1:0] BYTE_LAST = BW'(H_BYTES - 1);

  state_t                state, state_nxt;
  logic                  fetch_cyc, fetch_cyc_nxt;
  logic [LW-1:0]         line_idx, line_nxt;
  logic [BW-1:0]         byte_idx, byte_nxt;
  logic [ADDR_WIDTH-1:0] addr, addr_nxt;
  logic                  load_data;
  logic                  running;
  logic                  ph_tc, ph_nxt_xscl, ph_nxt_pre, ph_nxt_last;

  logic                  rd_en_nxt;
  logic [ADDR_WIDTH-1:0] rd_addr_nxt;
  logic                  xscl_nxt, lp_nxt, din_nxt, busy_nxt, fd_nxt;

  assign running = (state == ST_SHIFT) || (state == ST_LATCH);

  lcm_xscl_phase_gen #(
    .XSCL_DIV (XSCL_DIV)
  ) u_phase (
    .clk          (clk),
    .rst          (rst),
    .restart      (!running),
    .tc           (ph_tc),
    .nxt_xscl     (ph_nxt_xscl),
    .nxt_prefetch (ph_nxt_pre),
    .nxt_last     (ph_nxt_last)
  );

  always_comb begin
    state_nxt     = state;
    fetch_cyc_nxt = 1'b0;
    line_nxt      = line_idx;
    byte_nxt      = byte_idx;
    addr_nxt      = addr;
    load_data     = 1'b0;
    case (state)
      ST_IDLE: begin
        line_nxt = '0;
        byte_nxt = '0;
        addr_nxt = '0;
        if (enable) state_nxt = ST_FETCH;
      end
      ST_FETCH: begin
        if (!fetch_cyc) begin
          fetch_cyc_nxt = 1'b1;
        end else begin
          load_data = 1'b1;
          state_nxt = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (ph_tc) begin
          byte_nxt = byte_idx + BW'(1);
          // Wrap on the very last byte so addr never reaches H_BYTES*V_LINES
          if (line_idx == LINE_LAST && byte_idx == BYTE_LAST) addr_nxt = '0;
          else                                                addr_nxt = addr + ADDR_WIDTH'(1);
          if (byte_idx == BYTE_LAST) state_nxt = ST_LATCH;
          else                       load_data = 1'b1;
        end
      end
      ST_LATCH: begin
        if (ph_tc) begin
          byte_nxt = '0;
          if (line_idx == LINE_LAST) begin
            line_nxt  = '0;
            addr_nxt  = '0;
            state_nxt = enable ? ST_FETCH : ST_IDLE;
          end else begin
            line_nxt  = line_idx + LW'(1);
            state_nxt = ST_FETCH;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Output values for the upcoming cycle, registered so every pin is a flop
  always_comb begin
    rd_en_nxt   = 1'b0;
    rd_addr_nxt = rd_addr;
    if (state_nxt == ST_FETCH && !fetch_cyc_nxt) begin
      rd_en_nxt   = 1'b1;
      rd_addr_nxt = addr_nxt;
    end else if (state_nxt == ST_SHIFT && ph_nxt_pre && byte_nxt != BYTE_LAST) begin
      rd_en_nxt   = 1'b1;
      rd_addr_nxt = addr_nxt + ADDR_WIDTH'(1);
    end else if (state_nxt == ST_IDLE) begin
      rd_addr_nxt = '0;
    end
    xscl_nxt = (state_nxt == ST_SHIFT) && ph_nxt_xscl;
    lp_nxt   = (state_nxt == ST_LATCH);
    busy_nxt = (state_nxt != ST_IDLE);
    din_nxt  = busy_nxt && (line_nxt == '0);
    fd_nxt   = lp_nxt && ph_nxt_last && (line_nxt == LINE_LAST);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      fetch_cyc  <= 1'b0;
      line_idx   <= '0;
      byte_idx   <= '0;
      addr       <= '0;
      rd_en      <= 1'b0;
      rd_addr    <= '0;
      lcm_xscl   <= 1'b0;
      lcm_lp     <= 1'b0;
      lcm_din    <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      fetch_cyc  <= fetch_cyc_nxt;
      line_idx   <= line_nxt;
      byte_idx   <= byte_nxt;
      addr       <= addr_nxt;
      rd_en      <= rd_en_nxt;
      rd_addr    <= rd_addr_nxt;
      lcm_xscl   <= xscl_nxt;
      lcm_lp     <= lp_nxt;
      lcm_din    <= din_nxt;
      busy       <= busy_nxt;
      frame_done <= fd_nxt;
    end
  end

  // Panel data: loaded one cycle after each read, held through LATCH, cleared in IDLE
  always_ff @(posedge clk) begin
    if (rst)                        lcm_data <= '0;
    else if (state_nxt == ST_IDLE)  lcm_data <= '0;
    else if (load_data)             lcm_data <= rd_data;
  end

endmodule

// File: tb/tb_lcm_eg9013f_nz_scan_ctrl.sv
// Bench for the LCM scan sequencer: H=4, V=3 with XSCL_DIV=2 (dut_a) and XSCL_DIV=1 (dut_b).
module tb_lcm_eg9013f_nz_scan_ctrl;

  localparam int AW = 14;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_a, enable_a, rd_en_a, xscl_a, lp_a, din_a, busy_a, fd_a;
  logic [AW-1:0] rd_addr_a;
  logic [7:0]    rd_data_a, data_a;
  logic          rst_b, enable_b, rd_en_b, xscl_b, lp_b, din_b, busy_b, fd_b;
  logic [AW-1:0] rd_addr_b;
  logic [7:0]    rd_data_b, data_b;

  lcm_eg9013f_nz_scan_ctrl #(.BYTE_WIDTH(8), .H_BYTES(4), .V_LINES(3), .XSCL_DIV(2), .ADDR_WIDTH(AW)) dut_a (
    .clk(clk), .rst(rst_a), .enable(enable_a), .rd_en(rd_en_a), .rd_addr(rd_addr_a), .rd_data(rd_data_a),
    .lcm_data(data_a), .lcm_xscl(xscl_a), .lcm_lp(lp_a), .lcm_din(din_a), .busy(busy_a), .frame_done(fd_a));

  lcm_eg9013f_nz_scan_ctrl #(.BYTE_WIDTH(8), .H_BYTES(4), .V_LINES(3), .XSCL_DIV(1), .ADDR_WIDTH(AW)) dut_b (
    .clk(clk), .rst(rst_b), .enable(enable_b), .rd_en(rd_en_b), .rd_addr(rd_addr_b), .rd_data(rd_data_b),
    .lcm_data(data_b), .lcm_xscl(xscl_b), .lcm_lp(lp_b), .lcm_din(din_b), .busy(busy_b), .frame_done(fd_b));

  // Frame-buffer RAM model: byte[i] = 0x10 + i, one-cycle read latency
  always @(posedge clk) begin
    if (rd_en_a) rd_data_a <= 8'h10 + rd_addr_a[7:0];
    if (rd_en_b) rd_data_b <= 8'h10 + rd_addr_b[7:0];
  end

  typedef struct {
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [7:0]    data;
    logic          xscl, lp, din, busy, fd;
  } sample_t;

  typedef struct {
    int         c;
    logic       rd_en, xscl, lp, din, fd, busy;
    logic [7:0] data;
  } vec_t;

  sample_t    tr [0:255];
  vec_t       vt [15];
  int         q_addr [$];
  logic [7:0] q_data [$];
  int         total = 0;
  int         bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic sample_t sample(input int sel);
    sample_t s;
    if (sel == 0) begin
      s.rd_en = rd_en_a; s.rd_addr = rd_addr_a; s.data = data_a; s.xscl = xscl_a;
      s.lp = lp_a; s.din = din_a; s.busy = busy_a; s.fd = fd_a;
    end else begin
      s.rd_en = rd_en_b; s.rd_addr = rd_addr_b; s.data = data_b; s.xscl = xscl_b;
      s.lp = lp_b; s.din = din_b; s.busy = busy_b; s.fd = fd_b;
    end
    return s;
  endfunction

  function automatic logic [27:0] all_outs(input int sel);
    sample_t s;
    s = sample(sel);
    return {s.rd_en, s.rd_addr, s.data, s.xscl, s.lp, s.din, s.busy, s.fd};
  endfunction

  task automatic set_en(input int sel, input logic v);
    if (sel == 0) enable_a = v;
    else          enable_b = v;
  endtask

  task automatic push_frame();
    for (int i = 0; i < 12; i++) begin
      q_addr.push_back(i);
      q_data.push_back(8'(16 + i));
    end
  endtask

  // Runs n cycles with enable high for the first en_cycles edges; scoreboards reads and shifts
  task automatic capture(input int sel, input int n, input int en_cycles);
    logic px;
    int   ea;
    px = 1'b0;
    set_en(sel, 1'b1);
    for (int i = 0; i < n; i++) begin
      tick();
      tr[i] = sample(sel);
      if (i + 1 >= en_cycles) set_en(sel, 1'b0);
      if (tr[i].rd_en) begin
        if (q_addr.size() == 0) begin
          total++; bad++;
          $display("FAIL rd_en_unexpected cycle=%0d actual_addr=%0h required=none", i, tr[i].rd_addr);
        end else begin
          ea = q_addr.pop_front();
          chk($sformatf("rd_addr[c%0d]", i), 32'(tr[i].rd_addr), ea);
        end
      end
      if (px && !tr[i].xscl) begin
        if (q_data.size() == 0) begin
          total++; bad++;
          $display("FAIL xscl_fall_unexpected cycle=%0d actual_data=%0h required=none", i, tr[i].data);
        end else begin
          chk($sformatf("lcm_data[c%0d]", i), 32'(tr[i].data), 32'(q_data.pop_front()));
        end
      end
      px = tr[i].xscl;
    end
  endtask

  task automatic frame_test(input int sel, input int period, input int line_p, input int two_d, input string tag);
    int n, falls, lp_pulses, lp_cyc, din_in, din_all, fd_cnt, fd_idx;
    n = period + 14;
    falls = 0; lp_pulses = 0; lp_cyc = 0; din_in = 0; din_all = 0; fd_cnt = 0; fd_idx = -1;
    push_frame();
    capture(sel, n, 1);
    for (int i = 0; i < n; i++) begin
      if (i > 0 && tr[i-1].xscl && !tr[i].xscl) falls++;
      if (tr[i].lp) lp_cyc++;
      if (tr[i].lp && (i == 0 || !tr[i-1].lp)) lp_pulses++;
      if (tr[i].din) din_all++;
      if (tr[i].din && i < line_p) din_in++;
      if (tr[i].fd) begin
        fd_cnt++;
        if (fd_idx < 0) fd_idx = i;
      end
    end
    chk({tag, "_start_rd_en"}, 32'(tr[0].rd_en), 1);
    chk({tag, "_start_addr"}, 32'(tr[0].rd_addr), 0);
    chk({tag, "_start_din"}, 32'(tr[0].din), 1);
    chk({tag, "_xscl_falls"}, falls, 12);
    chk({tag, "_lp_pulses"}, lp_pulses, 3);
    chk({tag, "_lp_cycles"}, lp_cyc, 3 * two_d);
    chk({tag, "_din_line0"}, din_in, line_p);
    chk({tag, "_din_total"}, din_all, line_p);
    chk({tag, "_fd_count"}, fd_cnt, 1);
    chk({tag, "_fd_cycle"}, fd_idx, period - 1);
    chk({tag, "_idle_after"}, 32'(tr[period].busy), 0);
    chk({tag, "_q_addr_left"}, q_addr.size(), 0);
    chk({tag, "_q_data_left"}, q_data.size(), 0);
    q_addr.delete();
    q_data.delete();
  endtask

  initial begin
    int fdi [$];
    int falls;
    // cycle (from first rd_en), rd_en, xscl, lp, din, fd, busy, lcm_data
    vt[0]  = '{0,  1, 0, 0, 1, 0, 1, 8'h00};
    vt[1]  = '{1,  0, 0, 0, 1, 0, 1, 8'h00};
    vt[2]  = '{2,  0, 1, 0, 1, 0, 1, 8'h10};
    vt[3]  = '{4,  1, 0, 0, 1, 0, 1, 8'h10};
    vt[4]  = '{5,  0, 0, 0, 1, 0, 1, 8'h10};
    vt[5]  = '{6,  0, 1, 0, 1, 0, 1, 8'h11};
    vt[6]  = '{16, 0, 0, 0, 1, 0, 1, 8'h13};
    vt[7]  = '{18, 0, 0, 1, 1, 0, 1, 8'h13};
    vt[8]  = '{21, 0, 0, 1, 1, 0, 1, 8'h13};
    vt[9]  = '{22, 1, 0, 0, 0, 0, 1, 8'h13};
    vt[10] = '{24, 0, 1, 0, 0, 0, 1, 8'h14};
    vt[11] = '{45, 0, 0, 0, 0, 0, 1, 8'h17};
    vt[12] = '{62, 0, 0, 1, 0, 0, 1, 8'h1B};
    vt[13] = '{65, 0, 0, 1, 0, 1, 1, 8'h1B};
    vt[14] = '{66, 0, 0, 0, 0, 0, 0, 8'h00};

    rst_a = 1'b1; rst_b = 1'b1; enable_a = 1'b0; enable_b = 1'b0;
    repeat (3) tick();
    chk("reset_outs_a", 32'(all_outs(0)), 0);
    chk("reset_outs_b", 32'(all_outs(1)), 0);
    rst_a = 1'b0; rst_b = 1'b0;
    tick();

    // Single frame with a one-cycle enable pulse, then per-cycle vector table
    frame_test(0, 66, 22, 4, "single");
    foreach (vt[k]) begin
      chk($sformatf("vec_c%0d", vt[k].c),
          32'({tr[vt[k].c].rd_en, tr[vt[k].c].xscl, tr[vt[k].c].lp, tr[vt[k].c].din,
               tr[vt[k].c].fd, tr[vt[k].c].busy, tr[vt[k].c].data}),
          32'({vt[k].rd_en, vt[k].xscl, vt[k].lp, vt[k].din, vt[k].fd, vt[k].busy, vt[k].data}));
    end

    // Continuous: enable held across two frame ends, dropped mid third frame
    repeat (3) push_frame();
    capture(0, 210, 140);
    for (int i = 0; i < 210; i++) if (tr[i].fd) fdi.push_back(i);
    chk("cont_fd_count", fdi.size(), 3);
    if (fdi.size() == 3) begin
      chk("cont_fd0", fdi[0], 65);
      chk("cont_gap1", fdi[1] - fdi[0], 66);
      chk("cont_gap2", fdi[2] - fdi[1], 66);
      chk("cont_restart1", 32'({tr[fdi[0]+1].rd_en, tr[fdi[0]+1].rd_addr}), 32'({1'b1, 14'd0}));
      chk("cont_restart2", 32'({tr[fdi[1]+1].rd_en, tr[fdi[1]+1].rd_addr}), 32'({1'b1, 14'd0}));
      chk("cont_idle_after", 32'(tr[fdi[2]+1].busy), 0);
    end
    chk("cont_q_left", q_addr.size() + q_data.size(), 0);
    q_addr.delete(); q_data.delete();

    // Enable dropped during line 1: the frame still completes
    push_frame();
    capture(0, 80, 30);
    falls = 0;
    for (int i = 1; i < 80; i++) if (tr[i-1].xscl && !tr[i].xscl) falls++;
    chk("middis_falls", falls, 12);
    chk("middis_fd", 32'(tr[65].fd), 1);
    chk("middis_idle", 32'(tr[66].busy), 0);
    chk("middis_idle_end", 32'(tr[79].busy), 0);
    chk("middis_q_left", q_addr.size() + q_data.size(), 0);
    q_addr.delete(); q_data.delete();

    // Reset asserted during the line 1 LATCH
    enable_a = 1'b1;
    tick();
    chk("rl_start_rd_en", 32'(rd_en_a), 1);
    enable_a = 1'b0;
    repeat (41) tick();
    chk("rl_in_latch", 32'({lp_a, busy_a}), 32'(2'b11));
    rst_a = 1'b1;
    tick();
    chk("rl_outs_zero", 32'(all_outs(0)), 0);
    rst_a = 1'b0;
    tick();
    tick();
    chk("rl_still_idle", 32'(all_outs(0)), 0);
    frame_test(0, 66, 22, 4, "rl_restart");

    // XSCL_DIV=1 boundary
    frame_test(1, 36, 12, 2, "div1");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
